// File: rtl/packet_rx_mux_device_pkg.sv
// packet_rx_mux_device_pkg: register offsets, CTRL field positions and counter widths
package packet_rx_mux_device_pkg;
    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_POP    = 8'h08;
    localparam logic [7:0] REG_NEMPTY = 8'h0C;
    localparam logic [7:0] REG_PHASE  = 8'h10;
    localparam logic [7:0] REG_PKTCNT = 8'h14;
    localparam logic [7:0] REG_DATA   = 8'h20;
    localparam int CTRL_SEL_W   = 5;
    localparam int CTRL_CLR_BIT = 8;
    localparam int WORD_CNT_W   = 8;
    localparam int PKT_CNT_W    = 16;
endpackage

// File: rtl/packet_rx_chan_stats.sv
// packet_rx_chan_stats: per-channel word (saturating) and packet (wrapping) counters
module packet_rx_chan_stats
    import packet_rx_mux_device_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pop_effective,
    input  logic                  pkt_end,
    input  logic                  clear,
    output logic [WORD_CNT_W-1:0] word_cnt,
    output logic [PKT_CNT_W-1:0]  pkt_cnt
);
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            word_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (pop_effective) begin
            if (pkt_end) begin
                word_cnt <= '0;
                pkt_cnt  <= pkt_cnt + PKT_CNT_W'(1);
            end else if (word_cnt != '1) begin
                word_cnt <= word_cnt + WORD_CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/packet_rx_mux_device.sv
// packet_rx_mux_device: CPU-bus drain port for CHANNELS packet FIFOs; PACKET_RX_AUTO_POP_EN makes a last-slice read pop
module packet_rx_mux_device
    import packet_rx_mux_device_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 64
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       mem_valid,
    input  logic [7:0]                 mem_addr,
    input  logic [31:0]                mem_wdata,
    input  logic [3:0]                 mem_wstrb,
    output logic [31:0]                mem_rdata,
    output logic                       mem_ready,
    output logic [CHANNELS-1:0]        in_pop,
    input  logic [CHANNELS-1:0]        in_nempty,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    input  logic [CHANNELS-1:0]        in_end,
    output logic [8*CHANNELS-1:0]      out_phase_shift
);
    localparam int SLICES = DATA_W / 32;
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
`ifdef PACKET_RX_AUTO_POP_EN
    localparam logic AUTO_POP = 1'b1;
`else
    localparam logic AUTO_POP = 1'b0;
`endif
    logic armed, pop_pend, pop_fire, accept, we, re, sel_ok, is_data, auto_pop, pop_req, ctrl_wr, unused_ok;
    logic [CTRL_SEL_W-1:0] sel;
    logic [CW-1:0] idx, pop_ch;
    logic [7:0] addr;
    logic [2:0] k;
    logic [DATA_W-1:0] head;
    logic [31:0] slice, status, rd;
    logic [7:0] phase [CHANNELS];
    logic [WORD_CNT_W-1:0] word_cnt [CHANNELS];
    logic [PKT_CNT_W-1:0] pkt_cnt [CHANNELS];

    // armed only after mem_valid is seen low, so a held request completes once
    assign accept   = mem_valid && armed;
    assign we       = accept && |mem_wstrb;
    assign re       = accept && ~|mem_wstrb;
    assign addr     = {mem_addr[7:2], 2'b00};
    assign k        = mem_addr[4:2];
    assign is_data  = addr[7:5] == REG_DATA[7:5];
    assign sel_ok   = 32'(sel) < CHANNELS;
    assign idx      = CW'(sel);
    assign ctrl_wr  = we && addr == REG_CTRL;
    assign auto_pop = AUTO_POP && re && is_data && 32'(k) == SLICES - 1;
    assign pop_req  = sel_ok && ((we && addr == REG_POP) || auto_pop);
    assign head     = DATA_W'(in_data >> (32'(idx) * DATA_W));
    assign slice    = 32'(head >> {k, 5'b0});
    assign status   = {8'h0, word_cnt[idx], 12'h0, AUTO_POP, pop_pend, in_end[idx], in_nempty[idx]};
    assign in_pop   = pop_fire ? in_nempty & (CHANNELS'(1) << pop_ch) : '0;
    assign unused_ok = ^{mem_addr[1:0], mem_wdata[31:9]};

    always_comb begin
        rd = '0;
        case (addr)
            REG_CTRL:   rd = 32'(sel);
            REG_STATUS: rd = sel_ok ? status : '0;
            REG_NEMPTY: rd = 32'(in_nempty);
            REG_PHASE:  rd = sel_ok ? 32'(phase[idx]) : '0;
            REG_PKTCNT: rd = sel_ok ? 32'(pkt_cnt[idx]) : '0;
            default:    rd = is_data && sel_ok ? slice : '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            armed     <= 1'b0;
            sel       <= '0;
            pop_pend  <= 1'b0;
            pop_fire  <= 1'b0;
            pop_ch    <= '0;
            for (int i = 0; i < CHANNELS; i++) phase[i] <= '0;
        end else begin
            mem_ready <= accept;
            armed     <= !mem_valid;
            pop_pend  <= pop_req;
            pop_fire  <= pop_pend;
            if (accept) mem_rdata <= re ? rd : '0;
            if (pop_req) pop_ch <= idx;
            if (ctrl_wr) sel <= mem_wdata[CTRL_SEL_W-1:0];
            if (we && addr == REG_PHASE && sel_ok) phase[idx] <= mem_wdata[7:0];
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        packet_rx_chan_stats u_stats (
            .clk          (clk),
            .resetn       (resetn),
            .pop_effective(in_pop[c]),
            .pkt_end      (in_end[c]),
            .clear        (ctrl_wr && mem_wdata[CTRL_CLR_BIT] && 32'(mem_wdata[CTRL_SEL_W-1:0]) == c),
            .word_cnt     (word_cnt[c]),
            .pkt_cnt      (pkt_cnt[c])
        );
        assign out_phase_shift[c*8 +: 8] = phase[c];
    end
endmodule

// File: tb/tb_packet_rx_mux_device.sv
// tb_packet_rx_mux_device: scoreboard bench with FIFO environment model and register-level reference model
module tb_packet_rx_mux_device;
    localparam int CH = 4;
    localparam int DW = 64;
`ifdef PACKET_RX_AUTO_POP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    logic clk = 0, resetn = 0, mem_valid = 0, mem_ready;
    logic [7:0] mem_addr = 0;
    logic [31:0] mem_wdata = 0, mem_rdata;
    logic [3:0] mem_wstrb = 0;
    logic [CH-1:0] in_pop, in_nempty = 0, in_end = 0;
    logic [CH*DW-1:0] in_data = '0;
    logic [8*CH-1:0] out_phase_shift;

    typedef struct { bit chk; logic [7:0] a; logic [31:0] v; } rd_t;
    typedef struct { int cyc; logic [CH-1:0] v; } pop_t;
    rd_t exp_rd[$];
    pop_t exp_pop[$];
    logic [63:0] q_data [CH][$];
    bit q_end [CH][$];
    int wc [CH], pc [CH];
    logic [7:0] ph [CH];
    int sel, cyc, n_cmp, n_bad;

    packet_rx_mux_device #(.CHANNELS(CH), .DATA_W(DW)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .in_pop(in_pop), .in_nempty(in_nempty),
        .in_data(in_data), .in_end(in_end), .out_phase_shift(out_phase_shift)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [7:0] a_in);
        logic [7:0] a;
        logic [63:0] h;
        logic [31:0] ne;
        bit e;
        int k;
        a = {a_in[7:2], 2'b00};
        ne = 0;
        for (int c = 0; c < CH; c++) ne[c] = q_data[c].size() > 0;
        if (a == 8'h00) return 32'(sel);
        if (a == 8'h0C) return ne;
        if (sel >= CH) return 0;
        h = 0;
        e = 0;
        if (q_data[sel].size() > 0) begin
            h = q_data[sel][0];
            e = q_end[sel][0];
        end
        if (a == 8'h04) return {8'h0, 8'(wc[sel]), 12'h0, AUTO, 1'b0, e, ne[sel]};
        if (a == 8'h10) return 32'(ph[sel]);
        if (a == 8'h14) return 32'(pc[sel]);
        if (a >= 8'h20 && a < 8'h40) begin
            k = (int'(a) - 32) / 4;
            return k < DW / 32 ? 32'(h >> (32 * k)) : 0;
        end
        return 0;
    endfunction

    task automatic model_pop();
        pop_t p;
        if (sel < CH && q_data[sel].size() > 0) begin
            p.cyc = cyc + 2;
            p.v = CH'(1) << sel;
            exp_pop.push_back(p);
            if (q_end[sel][0]) begin
                wc[sel] = 0;
                pc[sel] = (pc[sel] + 1) % 65536;
            end else if (wc[sel] < 255) wc[sel]++;
        end
    endtask

    task automatic bus(input logic [7:0] a, input logic [31:0] d, input bit wr);
        rd_t e;
        int n;
        e.chk = !wr;
        e.a = a;
        e.v = wr ? 32'h0 : exp_read(a);
        exp_rd.push_back(e);
        mem_addr = a;
        mem_wdata = d;
        mem_wstrb = wr ? 4'hF : 4'h0;
        mem_valid = 1;
        if (wr) begin
            case ({a[7:2], 2'b00})
                8'h00: begin
                    sel = int'(d[4:0]);
                    if (d[8] && sel < CH) begin
                        wc[sel] = 0;
                        pc[sel] = 0;
                    end
                end
                8'h08: model_pop();
                8'h10: if (sel < CH) ph[sel] = d[7:0];
                default: ;
            endcase
        end else if (AUTO && int'({a[7:2], 2'b00}) == 32 + 4 * (DW / 32 - 1)) model_pop();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready && n < 20);
        if (!mem_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: no mem_ready for addr %02h", a);
        end
        @(posedge clk);
        #2 mem_valid = 0;
        mem_wstrb = 0;
        @(negedge clk);
        check("ready_one_cycle", 32'(mem_ready), 0);
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input int c, input logic [63:0] d, input bit e);
        q_data[c].push_back(d);
        q_end[c].push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_phase();
        logic [8*CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c*8 +: 8] = ph[c];
        check("phase_out", out_phase_shift, v);
    endtask

    // FIFO environment: pops whatever the DUT pulsed and presents the new head
    initial begin
        logic [CH-1:0] p;
        forever begin
            @(negedge clk);
            p = in_pop;
            @(posedge clk);
            #1;
            for (int c = 0; c < CH; c++) begin
                if (p[c] && q_data[c].size() > 0) begin
                    void'(q_data[c].pop_front());
                    void'(q_end[c].pop_front());
                end
                in_nempty[c] = q_data[c].size() > 0;
                in_data[c*DW +: DW] = q_data[c].size() > 0 ? q_data[c][0] : 64'h0;
                in_end[c] = q_data[c].size() > 0 ? q_end[c][0] : 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        rd_t e;
        pop_t p;
        logic [CH-1:0] ev;
        if (mem_ready) begin
            if (exp_rd.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_ready: rdata %08h expected no completion", mem_rdata);
            end else begin
                e = exp_rd.pop_front();
                if (e.chk) check($sformatf("read_%02h", e.a), mem_rdata, e.v);
            end
        end
        ev = 0;
        if (exp_pop.size() > 0 && exp_pop[0].cyc == cyc) begin
            p = exp_pop.pop_front();
            ev = p.v;
        end
        if (ev != 0 || in_pop != 0) check("in_pop", 32'(in_pop), 32'(ev));
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rd_t e;
        logic [7:0] ra [11] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h24, 8'h28, 8'h3C, 8'h40};
        logic [31:0] d;
        for (int c = 0; c < CH; c++) ph[c] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(mem_ready), 0);
        check("rst_rdata", mem_rdata, 0);
        check("rst_in_pop", 32'(in_pop), 0);
        check("rst_phase", out_phase_shift, 0);
        @(posedge clk);
        #2 resetn = 1;
        tick();
        bus(8'h04, 0, 0);
        bus(8'h0C, 0, 0);
        push_word(2, 64'h1122334455667788, 0);
        push_word(2, {$urandom, $urandom}, 0);
        push_word(2, {$urandom, $urandom}, 0);
        push_word(2, {$urandom, $urandom}, 1);
        tick();
        bus(8'h00, 2, 1);
        bus(8'h20, 0, 0);
        bus(8'h24, 0, 0);
        bus(8'h08, 0, 1);
        bus(8'h04, 0, 0);
        repeat (3) bus(8'h08, 0, 1);
        bus(8'h14, 0, 0);
        bus(8'h04, 0, 0);
        push_word(2, {$urandom, $urandom}, 0);
        tick();
        bus(8'h08, 0, 1);
        bus(8'h00, 1, 1);
        bus(8'h08, 0, 1);
        bus(8'h00, 3, 1);
        bus(8'h10, 32'h5A, 1);
        check_phase();
        bus(8'h10, 0, 0);
        bus(8'h00, 7, 1);
        bus(8'h10, 0, 0);
        bus(8'h10, 32'hA5, 1);
        bus(8'h08, 0, 1);
        bus(8'h04, 0, 0);
        bus(8'h20, 0, 0);
        check_phase();
        push_word(0, {$urandom, $urandom}, 0);
        tick();
        bus(8'h00, 0, 1);
        bus(8'h24, 0, 0);
        bus(8'h04, 0, 0);
        repeat (257) push_word(1, {$urandom, $urandom}, 0);
        tick();
        bus(8'h00, 1, 1);
        repeat (257) bus(8'h08, 0, 1);
        bus(8'h04, 0, 0);
        bus(8'h00, 32'h101, 1);
        bus(8'h04, 0, 0);
        bus(8'h14, 0, 0);
        repeat (300) begin
            case ($urandom_range(0, 6))
                0: begin
                    repeat ($urandom_range(1, 3)) push_word($urandom_range(0, CH - 1), {$urandom, $urandom}, $urandom_range(0, 3) == 0);
                    tick();
                end
                1: begin
                    d = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 5)) | ($urandom_range(0, 7) == 0 ? 32'h100 : 32'h0);
                    bus(8'h00, d, 1);
                end
                2: bus(8'h08, $urandom, 1);
                3: begin
                    bus(8'h10, $urandom, 1);
                    check_phase();
                end
                default: bus(ra[$urandom_range(0, 10)], 0, 0);
            endcase
        end
        // reset lands while a POP is pending: the pulse must never appear
        push_word(0, 64'hDEAD_BEEF_0BAD_F00D, 0);
        tick();
        bus(8'h00, 0, 1);
        e.chk = 0;
        e.a = 8'h08;
        e.v = 0;
        exp_rd.push_back(e);
        mem_addr = 8'h08;
        mem_wstrb = 4'hF;
        mem_valid = 1;
        @(posedge clk);
        #2 resetn = 0;
        mem_valid = 0;
        mem_wstrb = 0;
        sel = 0;
        for (int c = 0; c < CH; c++) begin
            wc[c] = 0;
            pc[c] = 0;
            ph[c] = 0;
        end
        repeat (3) begin
            @(negedge clk);
            check("reset_pop", 32'(in_pop), 0);
        end
        check("reset_ready", 32'(mem_ready), 0);
        check_phase();
        @(posedge clk);
        #2 resetn = 1;
        tick();
        bus(8'h04, 0, 0);
        bus(8'h0C, 0, 0);
        bus(8'h14, 0, 0);
        repeat (4) tick();
        check("leftover_reads", 32'(exp_rd.size()), 0);
        check("leftover_pops", 32'(exp_pop.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
